// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared types for the pipeline stall/flush controller.
// Holds the FSM state encodings and the strobe bundle driven toward PC/IF-ID/ID-EX.
// No logic here; imported by pipe_stall_ctrl and its sub-modules.
package pipe_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    // Pipeline register controls, kept together so each case sets all four at once.
    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic ifid_clr;
        logic idex_clr;
    } strobe_t;

    localparam strobe_t STRB_RUN    = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_clr: 1'b0, idex_clr: 1'b0};
    localparam strobe_t STRB_FLUSH  = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_clr: 1'b1, idex_clr: 1'b1};
    localparam strobe_t STRB_BUBBLE = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_clr: 1'b0, idex_clr: 1'b1};
    localparam strobe_t STRB_KILL   = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_clr: 1'b1, idex_clr: 1'b1};
    localparam strobe_t STRB_FREEZE = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_clr: 1'b0, idex_clr: 1'b0};

endpackage

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// sat_counter: saturating up-counter for performance statistics.
// Ports: clk, rst (sync, active-high, clears to 0), inc (count enable), q (count).
// One-cycle latency from inc to q; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (inc && (q != {WIDTH{1'b1}})) begin
            q <= q + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: turns load-use bubble, EX redirect and EX halt request into
//   PC/IF-ID/ID-EX enable and clear strobes; drains EX/MEM/WB before freezing on halt.
// Ports: clk, rst (sync, active-high); in: bubble, branch_taken, halt_req, resume;
//   out: pc_en, ifid_en, ifid_clr, idex_clr, halted, bubble_cnt, flush_cnt.
// Strobes are zero-latency (combinational from state + inputs); counters update next cycle.
// Optional: define STALL_PERF_CNT_EN to build the saturating stall/flush counters;
//   otherwise bubble_cnt/flush_cnt are tied to zero.
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH    = 32,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bubble,
    input  logic                 branch_taken,
    input  logic                 halt_req,
    input  logic                 resume,
    output logic                 pc_en,
    output logic                 ifid_en,
    output logic                 ifid_clr,
    output logic                 idex_clr,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] bubble_cnt,
    output logic [CNT_WIDTH-1:0] flush_cnt
);

    localparam int DW = $clog2(DRAIN_CYCLES) + 1;

    state_t        state;
    logic [DW-1:0] drain_cnt;
    strobe_t       strb;

    // Strobe decode. Reset forces a kill so no wrong instruction survives the reset cycle.
    always_comb begin
        strb = STRB_KILL;
        if (!rst) begin
            case (state)
                ST_RUN: begin
                    if (halt_req)          strb = STRB_KILL;
                    else if (branch_taken) strb = STRB_FLUSH;   // ID holds wrong path, bubble moot
                    else if (bubble)       strb = STRB_BUBBLE;
                    else                   strb = STRB_RUN;
                end
                ST_DRAIN:  strb = STRB_KILL;
                ST_HALTED: strb = STRB_FREEZE;                  // keep pipeline contents
                default:   strb = STRB_KILL;
            endcase
        end
    end

    assign pc_en    = strb.pc_en;
    assign ifid_en  = strb.ifid_en;
    assign ifid_clr = strb.ifid_clr;
    assign idex_clr = strb.idex_clr;
    assign halted   = !rst && (state == ST_HALTED);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_RUN;
            drain_cnt <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (halt_req) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= '0;
                    end
                end
                ST_DRAIN: begin
                    drain_cnt <= drain_cnt + DW'(1);
                    if (drain_cnt == DW'(DRAIN_CYCLES - 1)) state <= ST_HALTED;
                end
                ST_HALTED: begin
                    if (resume) state <= ST_RUN;
                end
                default: state <= ST_RUN;
            endcase
        end
    end

`ifdef STALL_PERF_CNT_EN
    // Count only when the corresponding strobe pattern is actually applied in RUN.
    logic run_live;
    logic bubble_inc;
    logic flush_inc;

    assign run_live   = !rst && (state == ST_RUN) && !halt_req;
    assign flush_inc  = run_live && branch_taken;
    assign bubble_inc = run_live && !branch_taken && bubble;

    sat_counter #(.WIDTH(CNT_WIDTH)) u_bubble_cnt (
        .clk (clk),
        .rst (rst),
        .inc (bubble_inc),
        .q   (bubble_cnt)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (flush_inc),
        .q   (flush_cnt)
    );
`else
    assign bubble_cnt = '0;
    assign flush_cnt  = '0;
`endif

endmodule
